// File: rtl/reg_space_arbiter_if.sv
// Valid/ready channel bundle between a configuration master and a register space:
// read request, read ack and write request.
interface reg_space_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rreq_addr;
  logic              rreq_vld;
  logic              rreq_rdy;
  logic [DATA_W-1:0] rack_data;
  logic              rack_err;
  logic              rack_vld;
  logic              rack_rdy;
  logic [ADDR_W-1:0] wreq_addr;
  logic [DATA_W-1:0] wreq_data;
  logic              wreq_vld;
  logic              wreq_rdy;

  // The register space never reports read errors, so the initiating side
  // towards it carries no rack_err.
  modport master (
    output rreq_addr, rreq_vld,
    input  rreq_rdy,
    input  rack_data, rack_vld,
    output rack_rdy,
    output wreq_addr, wreq_data, wreq_vld,
    input  wreq_rdy
  );

  modport slave (
    input  rreq_addr, rreq_vld,
    output rreq_rdy,
    output rack_data, rack_err, rack_vld,
    input  rack_rdy,
    input  wreq_addr, wreq_data, wreq_vld,
    output wreq_rdy
  );
endinterface

// File: rtl/reg_space_arbiter.sv
// Round-robin arbiter letting two configuration masters share one register space;
// the grant is held until the transaction completes, and hung reads end in an error ack.
module reg_space_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  reg_space_arbiter_if.slave  m0,
  reg_space_arbiter_if.slave  m1,
  reg_space_arbiter_if.master s,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WREQ = 3'd1,
    RREQ = 3'd2,
    RACK = 3'd3,
    RERR = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          gnt, gnt_nx;
  logic          prio, prio_nx;
  logic [TW-1:0] tcnt, tcnt_nx;

  logic              req0, req1;
  logic              winner;
  logic              win_wr;
  logic [ADDR_W-1:0] sel_wreq_addr;
  logic [DATA_W-1:0] sel_wreq_data;
  logic              sel_wreq_vld;
  logic [ADDR_W-1:0] sel_rreq_addr;
  logic              sel_rreq_vld;
  logic              sel_rack_rdy;

  // Request view of the granted master and the arbitration decision for IDLE.
  always_comb begin
    req0          = m0.wreq_vld | m0.rreq_vld;
    req1          = m1.wreq_vld | m1.rreq_vld;
    winner        = (prio ? req1 : req0) ? prio : ~prio;
    win_wr        = winner ? m1.wreq_vld : m0.wreq_vld;
    sel_wreq_addr = gnt ? m1.wreq_addr : m0.wreq_addr;
    sel_wreq_data = gnt ? m1.wreq_data : m0.wreq_data;
    sel_wreq_vld  = gnt ? m1.wreq_vld  : m0.wreq_vld;
    sel_rreq_addr = gnt ? m1.rreq_addr : m0.rreq_addr;
    sel_rreq_vld  = gnt ? m1.rreq_vld  : m0.rreq_vld;
    sel_rack_rdy  = gnt ? m1.rack_rdy  : m0.rack_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      prio  <= prio_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Priority flips only on completion, so continuous contention alternates.
  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    prio_nx  = prio;
    tcnt_nx  = tcnt;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_nx   = winner;
          state_nx = win_wr ? WREQ : RREQ;
        end
      end
      WREQ: begin
        if (sel_wreq_vld && s.wreq_rdy) begin
          state_nx = IDLE;
          prio_nx  = ~gnt;
        end
      end
      RREQ: begin
        if (sel_rreq_vld && s.rreq_rdy) begin
          state_nx = RACK;
          tcnt_nx  = '0;
        end
      end
      RACK: begin
        // A real ack on the last allowed cycle still beats the timeout.
        if (s.rack_vld && sel_rack_rdy) begin
          state_nx = IDLE;
          prio_nx  = ~gnt;
        end else if (tcnt == TLAST) begin
          state_nx = RERR;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      RERR: begin
        if (sel_rack_rdy) begin
          state_nx = IDLE;
          prio_nx  = ~gnt;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only the channel matching the current state is routed; everything else is zero.
  always_comb begin
    m0.rreq_rdy  = 1'b0;
    m0.rack_data = '0;
    m0.rack_err  = 1'b0;
    m0.rack_vld  = 1'b0;
    m0.wreq_rdy  = 1'b0;
    m1.rreq_rdy  = 1'b0;
    m1.rack_data = '0;
    m1.rack_err  = 1'b0;
    m1.rack_vld  = 1'b0;
    m1.wreq_rdy  = 1'b0;
    s.rreq_addr  = '0;
    s.rreq_vld   = 1'b0;
    s.rack_rdy   = 1'b0;
    s.wreq_addr  = '0;
    s.wreq_data  = '0;
    s.wreq_vld   = 1'b0;
    busy         = (state != IDLE);
    case (state)
      WREQ: begin
        s.wreq_addr = sel_wreq_addr;
        s.wreq_data = sel_wreq_data;
        s.wreq_vld  = sel_wreq_vld;
        if (gnt) m1.wreq_rdy = s.wreq_rdy;
        else     m0.wreq_rdy = s.wreq_rdy;
      end
      RREQ: begin
        s.rreq_addr = sel_rreq_addr;
        s.rreq_vld  = sel_rreq_vld;
        if (gnt) m1.rreq_rdy = s.rreq_rdy;
        else     m0.rreq_rdy = s.rreq_rdy;
      end
      RACK: begin
        s.rack_rdy = sel_rack_rdy;
        if (gnt) begin
          m1.rack_data = s.rack_data;
          m1.rack_vld  = s.rack_vld;
        end else begin
          m0.rack_data = s.rack_data;
          m0.rack_vld  = s.rack_vld;
        end
      end
      RERR: begin
        // Late acks from the register space are swallowed here.
        s.rack_rdy = 1'b1;
        if (gnt) begin
          m1.rack_vld = 1'b1;
          m1.rack_err = 1'b1;
        end else begin
          m0.rack_vld = 1'b1;
          m0.rack_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_space_arbiter.sv
// Directed bench for reg_space_arbiter: writes, round-robin alternation, reads,
// timeout error completion, write-before-read and reset mid-transaction.
module tb_reg_space_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   errors = 0;
  int   checks = 0;

  reg_space_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
  reg_space_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();
  reg_space_arbiter_if #(.ADDR_W(16), .DATA_W(32)) s_if ();

  reg_space_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m0   (m0_if),
    .m1   (m1_if),
    .s    (s_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m0_if.rreq_addr = '0; m0_if.rreq_vld = 0; m0_if.rack_rdy = 0;
    m0_if.wreq_addr = '0; m0_if.wreq_data = '0; m0_if.wreq_vld = 0;
    m1_if.rreq_addr = '0; m1_if.rreq_vld = 0; m1_if.rack_rdy = 0;
    m1_if.wreq_addr = '0; m1_if.wreq_data = '0; m1_if.wreq_vld = 0;
    s_if.rreq_rdy = 0; s_if.rack_data = '0; s_if.rack_vld = 0; s_if.rack_err = 0;
    s_if.wreq_rdy = 0;

    // Reset and idle
    tick();
    tick();
    check_output("rst_busy", busy, 0);
    check_output("rst_s_wvld", s_if.wreq_vld, 0);
    check_output("rst_s_rvld", s_if.rreq_vld, 0);
    check_output("rst_s_rack_rdy", s_if.rack_rdy, 0);
    check_output("rst_m0_rack_vld", m0_if.rack_vld, 0);
    check_output("rst_m1_rack_vld", m1_if.rack_vld, 0);
    rst_n = 1'b1;

    // Single write from m0
    s_if.wreq_rdy = 1; s_if.rreq_rdy = 1;
    m0_if.wreq_addr = 16'h0004; m0_if.wreq_data = 32'hA5A5_0001; m0_if.wreq_vld = 1;
    #1;
    check_output("w0_idle_s_vld", s_if.wreq_vld, 0);
    check_output("w0_idle_m0_rdy", m0_if.wreq_rdy, 0);
    tick();
    check_output("w0_s_vld", s_if.wreq_vld, 1);
    check_output("w0_s_addr", s_if.wreq_addr, 16'h0004);
    check_output("w0_s_data", s_if.wreq_data, 32'hA5A5_0001);
    check_output("w0_m0_rdy", m0_if.wreq_rdy, 1);
    check_output("w0_busy", busy, 1);
    tick();
    m0_if.wreq_vld = 0;
    #1;
    check_output("w0_m0_rdy_drop", m0_if.wreq_rdy, 0);
    check_output("w0_done_busy", busy, 0);

    // prio is now 1: simultaneous writes go to m1 first
    m0_if.wreq_addr = 16'h0010; m0_if.wreq_data = 32'h1; m0_if.wreq_vld = 1;
    m1_if.wreq_addr = 16'h0020; m1_if.wreq_data = 32'h2; m1_if.wreq_vld = 1;
    tick();
    check_output("prio_s_addr", s_if.wreq_addr, 16'h0020);
    check_output("prio_m1_rdy", m1_if.wreq_rdy, 1);
    check_output("prio_m0_rdy", m0_if.wreq_rdy, 0);
    tick();
    m1_if.wreq_vld = 0;
    #1;
    check_output("prio_gap_busy", busy, 0);
    tick();
    check_output("prio_m0_addr", s_if.wreq_addr, 16'h0010);
    tick();
    m0_if.wreq_vld = 0;

    // Reset, then both masters write continuously
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_if.wreq_addr = 16'h0100; m0_if.wreq_data = 32'hAAAA_0000; m0_if.wreq_vld = 1;
    m1_if.wreq_addr = 16'h0200; m1_if.wreq_data = 32'hBBBB_0000; m1_if.wreq_vld = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_output("rr_idle_busy", busy, 0);
      check_output("rr_idle_vld", s_if.wreq_vld, 0);
      tick();
      check_output("rr_vld", s_if.wreq_vld, 1);
      check_output("rr_addr", s_if.wreq_addr, (i % 2 == 1) ? 16'h0200 : 16'h0100);
      check_output("rr_data", s_if.wreq_data, (i % 2 == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000);
      tick();
    end
    m0_if.wreq_vld = 0; m1_if.wreq_vld = 0;

    // m1 read of 0x0008 acked 3 cycles after the rreq handshake
    m1_if.rreq_addr = 16'h0008; m1_if.rreq_vld = 1; m1_if.rack_rdy = 1;
    tick();
    check_output("rd1_s_rvld", s_if.rreq_vld, 1);
    check_output("rd1_s_raddr", s_if.rreq_addr, 16'h0008);
    check_output("rd1_m1_rrdy", m1_if.rreq_rdy, 1);
    check_output("rd1_m0_rrdy", m0_if.rreq_rdy, 0);
    tick();
    m1_if.rreq_vld = 0;
    #1;
    check_output("rd1_wait_vld", m1_if.rack_vld, 0);
    check_output("rd1_s_rack_rdy", s_if.rack_rdy, 1);
    tick();
    tick();
    s_if.rack_vld = 1; s_if.rack_data = 32'h1234_5678;
    #1;
    check_output("rd1_m1_vld", m1_if.rack_vld, 1);
    check_output("rd1_m1_data", m1_if.rack_data, 32'h1234_5678);
    check_output("rd1_m1_err", m1_if.rack_err, 0);
    check_output("rd1_m0_vld", m0_if.rack_vld, 0);
    check_output("rd1_m0_data", m0_if.rack_data, 0);
    tick();
    s_if.rack_vld = 0;
    #1;
    check_output("rd1_done_busy", busy, 0);

    // m0 read with no ack: timeout after 4 RACK cycles
    m0_if.rreq_addr = 16'h000C; m0_if.rreq_vld = 1; m0_if.rack_rdy = 0;
    tick();
    tick();
    m0_if.rreq_vld = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output("to_wait_vld", m0_if.rack_vld, 0);
      check_output("to_wait_busy", busy, 1);
      tick();
    end
    check_output("to_vld", m0_if.rack_vld, 1);
    check_output("to_data", m0_if.rack_data, 0);
    check_output("to_err", m0_if.rack_err, 1);
    check_output("to_s_rack_rdy", s_if.rack_rdy, 1);
    s_if.rack_vld = 1; s_if.rack_data = 32'hDEAD_BEEF;
    #1;
    check_output("to_late_data", m0_if.rack_data, 0);
    check_output("to_late_m1", m1_if.rack_vld, 0);
    tick();
    s_if.rack_vld = 0;
    check_output("to_hold_vld", m0_if.rack_vld, 1);
    m0_if.rack_rdy = 1;
    tick();
    check_output("to_done_busy", busy, 0);

    // Next grant after the error goes to m1
    m0_if.wreq_addr = 16'h0030; m0_if.wreq_data = 32'h3; m0_if.wreq_vld = 1;
    m1_if.wreq_addr = 16'h0040; m1_if.wreq_data = 32'h4; m1_if.wreq_vld = 1;
    tick();
    check_output("after_to_m1_rdy", m1_if.wreq_rdy, 1);
    check_output("after_to_addr", s_if.wreq_addr, 16'h0040);
    tick();
    m1_if.wreq_vld = 0;
    tick();
    check_output("after_to_m0_addr", s_if.wreq_addr, 16'h0030);
    tick();
    m0_if.wreq_vld = 0;

    // m1 read acked on the last RACK cycle: normal completion wins
    m1_if.rreq_addr = 16'h0050; m1_if.rreq_vld = 1; m1_if.rack_rdy = 1;
    tick();
    tick();
    m1_if.rreq_vld = 0;
    tick();
    tick();
    tick();
    s_if.rack_vld = 1; s_if.rack_data = 32'hCAFE_0001;
    #1;
    check_output("edge_vld", m1_if.rack_vld, 1);
    check_output("edge_err", m1_if.rack_err, 0);
    check_output("edge_data", m1_if.rack_data, 32'hCAFE_0001);
    tick();
    s_if.rack_vld = 0;
    #1;
    check_output("edge_busy", busy, 0);
    check_output("edge_no_rerr", m1_if.rack_vld, 0);

    // m0 read and write together: write first
    m0_if.wreq_addr = 16'h0060; m0_if.wreq_data = 32'h66; m0_if.wreq_vld = 1;
    m0_if.rreq_addr = 16'h0070; m0_if.rreq_vld = 1;
    tick();
    check_output("wr1st_wvld", s_if.wreq_vld, 1);
    check_output("wr1st_rvld", s_if.rreq_vld, 0);
    tick();
    m0_if.wreq_vld = 0;
    tick();
    check_output("wr1st_read_vld", s_if.rreq_vld, 1);
    check_output("wr1st_read_addr", s_if.rreq_addr, 16'h0070);
    tick();
    m0_if.rreq_vld = 0;
    s_if.rack_vld = 1; s_if.rack_data = 32'h55;
    #1;
    check_output("wr1st_rack_data", m0_if.rack_data, 32'h55);
    tick();
    s_if.rack_vld = 0;

    // Reset during RACK abandons the read
    m1_if.rreq_addr = 16'h0080; m1_if.rreq_vld = 1;
    tick();
    tick();
    m1_if.rreq_vld = 0;
    tick();
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_busy_before", busy, 1);
    tick();
    rst_n = 1'b1;
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_s_rack_rdy", s_if.rack_rdy, 0);
    check_output("rst_mid_m1_rrdy", m1_if.rreq_rdy, 0);
    s_if.rack_vld = 1; s_if.rack_data = 32'h77;
    #1;
    check_output("rst_mid_m1_vld", m1_if.rack_vld, 0);
    check_output("rst_mid_m0_vld", m0_if.rack_vld, 0);
    tick();
    check_output("rst_mid_m1_vld2", m1_if.rack_vld, 0);
    s_if.rack_vld = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_space_arbiter.md
# reg_space_arbiter

Two-master arbiter placed in front of a `RegSpaceBase_*` register space. It lets the APB bridge and a second internal configuration master, such as a boot sequencer or debug port, share one register bank. Each master sees its own read-request, read-ack and write-request channels. The arbiter grants one master at a time in round-robin order and holds the grant until that master's transaction completes. A hung read is completed by a timeout that returns an error response.

## Interface
Parameters:
- ADDR_W, 16, request address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles in RACK before an error completion is forced; must be ≥ 1; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- mN_rreq_addr  in  ADDR_W  master N read address (N = 0, 1; the same channel set exists for each master)
- mN_rreq_vld / mN_rreq_rdy  in / out  1  master N read-request handshake
- mN_rack_data  out  DATA_W  master N read data
- mN_rack_err  out  1  read error flag, qualified by mN_rack_vld
- mN_rack_vld / mN_rack_rdy  out / in  1  master N read-ack handshake
- mN_wreq_addr  in  ADDR_W  master N write address
- mN_wreq_data  in  DATA_W  master N write data
- mN_wreq_vld / mN_wreq_rdy  in / out  1  master N write-request handshake
- s_rreq_addr, s_rreq_vld  out  ADDR_W, 1  read request to the register space
- s_rreq_rdy  in  1  read-request ready from the register space
- s_rack_data, s_rack_vld  in  DATA_W, 1  read ack from the register space
- s_rack_rdy  out  1  read-ack ready to the register space
- s_wreq_addr, s_wreq_data, s_wreq_vld  out  ADDR_W, DATA_W, 1  write request to the register space
- s_wreq_rdy  in  1  write-request ready from the register space
- busy  out  1  high in any state other than IDLE

## Operation
- All channels use valid/ready.
  - A transfer occurs on the cycle where vld && rdy.
  - Masters hold vld and payload stable until rdy.
  - The register space may return rack any number of cycles (≥ 0) after the rreq handshake.
- Registered state: `state` ∈ {IDLE, WREQ, RREQ, RACK, RERR}, `gnt` (1 bit), `prio` (1 bit, the master with priority), and a timeout counter `tcnt`.
- **IDLE**
  - reqN = mN_wreq_vld | mN_rreq_vld.
  - Winner: master `prio` if req[prio] is set, otherwise the other master if it is requesting.
  - Within the winner, a write takes precedence over a read.
  - Next cycle: `gnt` = winner; state = WREQ for a write, RREQ for a read.
  - With no requests, stay in IDLE.
  - No s_* vld and no m* rdy is asserted in IDLE.
- **WREQ**
  - s_wreq_* = m[gnt]_wreq_* and m[gnt]_wreq_rdy = s_wreq_rdy, combinationally.
  - On handshake: go to IDLE, set prio = ~gnt.
- **RREQ**
  - s_rreq_* = m[gnt]_rreq_* and m[gnt]_rreq_rdy = s_rreq_rdy.
  - On handshake: go to RACK, clear tcnt.
- **RACK**
  - m[gnt]_rack_data/vld = s_rack_data/vld, s_rack_rdy = m[gnt]_rack_rdy, rack_err = 0.
  - On handshake: go to IDLE, set prio = ~gnt.
  - Otherwise tcnt increments by 1 each cycle; when tcnt == TIMEOUT-1 and no handshake occurs that cycle, go to RERR.
- **RERR**
  - m[gnt]_rack_vld = 1, rack_data = 0, rack_err = 1.
  - s_rack_rdy = 1, so any late ack from the register space is absorbed and dropped.
  - On m[gnt]_rack_rdy: go to IDLE, set prio = ~gnt.
- The non-granted master's rdy and vld outputs are always 0 and its data outputs are 0.
- All s_* outputs are 0 when their channel is not being forwarded.

## Timing
- Reset (rst_n sampled low at a posedge): state = IDLE, gnt = 0, prio = 0, tcnt = 0.
  - Every output is 0, including busy.
  - Reset during any transaction abandons it. No completion is issued for it.
- Arbitration costs exactly one cycle.
  - A request first seen in IDLE at cycle t can be forwarded at t+1 at the earliest.
  - A write completes at t+1 if s_wreq_rdy = 1.
- Fastest read: rreq handshake at t+1, rack at t+2 if s_rack_vld and rdy are high.
- Back-to-back transactions: at least one IDLE cycle separates them.
- Simultaneous requests: prio decides. Because prio flips after every completed transaction, both masters requesting continuously alternate.
- The timeout counter does not wrap. Error completion appears exactly TIMEOUT cycles after entering RACK.
- A rack handshake in the same cycle that tcnt reaches TIMEOUT-1 wins: normal completion, no RERR.

## Test plan
- Reset then idle → all outputs 0. Write from m0 only (addr 0x0004, data 0xA5A5_0001), s_wreq_rdy = 1 → s_wreq_vld at cycle 1 with the same addr/data; m0_wreq_rdy for exactly one cycle; prio becomes 1.
- m0 and m1 both write continuously after reset → s_wreq carries m0, m1, m0, m1 payloads; one IDLE cycle between each.
- m1 read of 0x0008, register space acks 3 cycles after the rreq handshake with 0x1234_5678 → m1_rack_data = 0x1234_5678, err = 0; m0 outputs stay 0 throughout.
- TIMEOUT = 4, m0 read with no s_rack_vld → m0_rack_vld = 1, data = 0, err = 1, asserted 4 cycles after entering RACK. s_rack_vld pulsed during RERR is dropped. Next grant goes to m1.
- m0 asserts rreq and wreq together → write is served first. The read is served in a later transaction.
- rst_n low for one cycle mid-RACK → next cycle state = IDLE, busy = 0, all vld/rdy outputs 0. A later s_rack_vld is not forwarded to either master.
